// File: rtl/hmcs_key_display_io.sv
// HMCS44A peripheral responder: qualifies one-hot D strobes, latches R2/R3 segment data
// into a 16-entry display RAM, debounces the strobed key column and pulses int0 on changes.
module hmcs_key_display_io #(
    parameter int STROBE_MIN = 4,
    parameter int DEB        = 16,
    parameter int INT_LEN    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_D,
    input  logic [3:0]  i_R2,
    input  logic [3:0]  i_R3,
    input  logic [63:0] i_keys,
    output logic [3:0]  o_R0,
    output logic        o_int0,
    output logic [3:0]  o_col,
    output logic        o_col_valid,
    input  logic [3:0]  i_disp_addr,
    output logic [7:0]  o_disp_data,
    output logic [1:0]  o_state
);

    localparam int CW = $clog2(STROBE_MIN + 1);
    localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam int IW = $clog2(INT_LEN + 1);
    localparam logic [CW-1:0] SM_C     = CW'(STROBE_MIN);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB - 1);
    localparam logic [IW-1:0] INT_C    = IW'(INT_LEN);
    localparam bit            IMMED    = (STROBE_MIN == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q;
    logic [15:0]     d_q;
    logic [3:0]      col_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   dcnt_q;
    logic [3:0]      cand_q;
    logic [IW-1:0]   int_cnt_q;
    logic [7:0]      dram_q [16];
    logic [3:0]      deb_q  [16];

    logic            onehot;
    logic [3:0]      idx;
    logic            eval_en;
    logic            accept_en;
    logic [3:0]      acc_col;
    logic [3:0]      raw;

    // Any departure from the sampled strobe (or an unknown state) re-evaluates i_D.
    always_comb begin
        onehot = (i_D != 16'h0) && ((i_D & (i_D - 16'd1)) == 16'h0);
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (i_D[i]) idx = 4'(i);
        end
        eval_en   = ((state_q != S_ARM) && (state_q != S_HOLD)) || (i_D != d_q);
        accept_en = 1'b0;
        acc_col   = col_q;
        if (eval_en) begin
            accept_en = onehot && IMMED;
            acc_col   = idx;
        end else if (state_q == S_ARM) begin
            accept_en = ((cnt_q + 1'b1) == SM_C);
        end
        raw = i_keys[{col_q, 2'b00} +: 4];
    end

    assign o_state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            d_q         <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            cand_q      <= '0;
            int_cnt_q   <= '0;
            o_R0        <= '0;
            o_int0      <= 1'b0;
            o_col       <= '0;
            o_col_valid <= 1'b0;
            o_disp_data <= '0;
            for (int i = 0; i < 16; i++) begin
                dram_q[i] <= '0;
                deb_q[i]  <= '0;
            end
        end else begin
            o_disp_data <= dram_q[i_disp_addr];
            o_R0        <= (state_q == S_HOLD) ? deb_q[col_q] : 4'h0;
            o_col_valid <= (state_q == S_HOLD);
            o_col       <= col_q;
            o_int0      <= (int_cnt_q != '0);
            if (int_cnt_q != '0) int_cnt_q <= int_cnt_q - 1'b1;

            if (eval_en) begin
                if (onehot) begin
                    d_q     <= i_D;
                    col_q   <= idx;
                    cnt_q   <= CW'(1);
                    state_q <= S_ARM;
                end else begin
                    state_q <= S_IDLE;
                end
            end else if (state_q == S_ARM) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (state_q == S_HOLD) begin
                if (raw != cand_q) begin
                    cand_q <= raw;
                    dcnt_q <= '0;
                end else if (dcnt_q == DEB_MAX) begin
                    if (cand_q != deb_q[col_q]) begin
                        deb_q[col_q] <= cand_q;
                        int_cnt_q    <= INT_C;
                    end
                end else begin
                    dcnt_q <= dcnt_q + 1'b1;
                end
            end

            // Accept overrides the FSM moves above and restarts debounce for the new column.
            if (accept_en) begin
                dram_q[acc_col] <= {i_R2, i_R3};
                cand_q          <= i_keys[{acc_col, 2'b00} +: 4];
                dcnt_q          <= '0;
                state_q         <= S_HOLD;
            end
        end
    end

endmodule

// File: tb/tb_hmcs_key_display_io.sv
// Directed bench for hmcs_key_display_io with a queue-based scoreboard of expected outputs.
module tb_hmcs_key_display_io;

    logic        clk;
    logic        reset;
    logic [15:0] i_D;
    logic [3:0]  i_R2;
    logic [3:0]  i_R3;
    logic [63:0] i_keys;
    logic [3:0]  o_R0;
    logic        o_int0;
    logic [3:0]  o_col;
    logic        o_col_valid;
    logic [3:0]  i_disp_addr;
    logic [7:0]  o_disp_data;
    logic [1:0]  o_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    hmcs_key_display_io #(.STROBE_MIN(4), .DEB(16), .INT_LEN(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_D         (i_D),
        .i_R2        (i_R2),
        .i_R3        (i_R3),
        .i_keys      (i_keys),
        .o_R0        (o_R0),
        .o_int0      (o_int0),
        .o_col       (o_col),
        .o_col_valid (o_col_valid),
        .i_disp_addr (i_disp_addr),
        .o_disp_data (o_disp_data),
        .o_state     (o_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [7:0] obs);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed %h expected <empty queue>", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    // Status word: {2'b00, o_col_valid, o_int0, o_R0}
    task automatic step_status(input string tag, input logic [7:0] exp);
        exp_q.push_back(exp);
        tick();
        pop_check(tag, {2'b00, o_col_valid, o_int0, o_R0});
    endtask

    task automatic step_disp(input string tag, input logic [3:0] addr, input logic [7:0] exp);
        i_disp_addr = addr;
        exp_q.push_back(exp);
        tick();
        pop_check(tag, o_disp_data);
    endtask

    initial begin
        reset       = 1'b0;
        i_D         = 16'h0;
        i_R2        = 4'h0;
        i_R3        = 4'h0;
        i_keys      = 64'h0;
        i_disp_addr = 4'h0;
        @(negedge clk);
        check("rst_R0", {4'h0, o_R0}, 8'h00);
        check("rst_int0", {7'h0, o_int0}, 8'h00);
        check("rst_col", {4'h0, o_col}, 8'h00);
        check("rst_col_valid", {7'h0, o_col_valid}, 8'h00);
        check("rst_disp", o_disp_data, 8'h00);
        check("rst_state", {6'h0, o_state}, 8'h00);
        reset = 1'b1;
        tick();

        // Display latch, including read-during-write at the accept edge.
        i_D = 16'h0020; i_R2 = 4'hA; i_R3 = 4'h5;
        for (int t = 1; t <= 5; t++) begin
            step_disp("disp_latch", 4'h5, (t >= 5) ? 8'hA5 : 8'h00);
            check("disp_cv", {7'h0, o_col_valid}, (t >= 5) ? 8'h01 : 8'h00);
        end
        check("disp_col", {4'h0, o_col}, 8'h05);
        step_disp("disp_other4", 4'h4, 8'h00);
        step_disp("disp_other6", 4'h6, 8'h00);
        i_D = 16'h0000;
        tick();
        check("drop_cv_hold", {7'h0, o_col_valid}, 8'h01);
        tick();
        check("drop_cv_low", {7'h0, o_col_valid}, 8'h00);

        // Glitch: short strobe and non-one-hot strobe.
        i_D = 16'h0008; i_R2 = 4'hF; i_R3 = 4'hF;
        for (int t = 1; t <= 3; t++) begin
            step_disp("glitch_disp", 4'h3, 8'h00);
            check("glitch_cv", {7'h0, o_col_valid}, 8'h00);
        end
        i_D = 16'h0000;
        for (int t = 1; t <= 3; t++) begin
            step_disp("glitch_nowrite", 4'h3, 8'h00);
            check("glitch_cv2", {7'h0, o_col_valid}, 8'h00);
        end
        i_D = 16'h0011;
        for (int t = 1; t <= 10; t++) begin
            tick();
            check("multi_idle", {6'h0, o_state}, 8'h00);
        end
        i_D = 16'h0000;
        tick();

        // Debounce and interrupt on column 1.
        i_keys[7:4] = 4'b0100;
        i_D = 16'h0002;
        for (int t = 1; t <= 30; t++) begin
            step_status("deb_col1", {2'b00, (t >= 5), (t >= 21 && t <= 28),
                                     ((t >= 21) ? 4'h4 : 4'h0)});
        end

        // Bounce on key bit 5, then hold stable.
        for (int p = 0; p < 8; p++) begin
            i_keys[5] = ~i_keys[5];
            for (int k = 0; k < 5; k++) begin
                step_status("bounce", {2'b00, 1'b1, 1'b0, 4'h4});
            end
        end
        i_keys[5] = 1'b1;
        for (int t = 1; t <= 26; t++) begin
            step_status("bounce_settle", {2'b00, 1'b1, (t >= 18 && t <= 25),
                                          ((t >= 18) ? 4'h6 : 4'h4)});
        end

        // Column switch between committed columns 0 and 3.
        i_keys[3:0]   = 4'h1;
        i_keys[15:12] = 4'h8;
        i_D = 16'h0001;
        repeat (30) tick();
        check("col0_deb", {4'h0, o_R0}, 8'h01);
        check("col0_int_done", {7'h0, o_int0}, 8'h00);
        i_D = 16'h0008;
        repeat (30) tick();
        check("col3_deb", {4'h0, o_R0}, 8'h08);
        check("col3_int_done", {7'h0, o_int0}, 8'h00);
        for (int s = 0; s < 4; s++) begin
            logic [3:0] prev_v;
            logic [3:0] new_v;
            prev_v = (s % 2 == 0) ? 4'h8 : 4'h1;
            new_v  = (s % 2 == 0) ? 4'h1 : 4'h8;
            i_D = (s % 2 == 0) ? 16'h0001 : 16'h0008;
            for (int t = 1; t <= 8; t++) begin
                step_status("col_switch", {2'b00, (t == 1 || t >= 5), 1'b0,
                                           ((t == 1) ? prev_v : ((t >= 5) ? new_v : 4'h0))});
            end
        end

        // Async reset mid-HOLD with the interrupt active.
        i_keys[15:12] = 4'hC;
        repeat (19) tick();
        check("pre_rst_int0", {7'h0, o_int0}, 8'h01);
        check("pre_rst_R0", {4'h0, o_R0}, 8'h0C);
        #2;
        reset = 1'b0;
        #1;
        check("arst_R0", {4'h0, o_R0}, 8'h00);
        check("arst_int0", {7'h0, o_int0}, 8'h00);
        check("arst_col", {4'h0, o_col}, 8'h00);
        check("arst_cv", {7'h0, o_col_valid}, 8'h00);
        check("arst_disp", o_disp_data, 8'h00);
        check("arst_state", {6'h0, o_state}, 8'h00);
        i_D = 16'h0000;
        @(negedge clk);
        reset = 1'b1;
        step_disp("post_rst_disp5", 4'h5, 8'h00);
        step_disp("post_rst_disp0", 4'h0, 8'h00);
        step_disp("post_rst_disp3", 4'h3, 8'h00);
        check("post_rst_cv", {7'h0, o_col_valid}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
